// File: rtl/wb_spi_pkg.sv
// Shared register map, control/status bit positions and shifter state encoding
// for the Wishbone SPI master.
package wb_spi_pkg;

  localparam logic [7:0] ADDR_STATUS = 8'h00;
  localparam logic [7:0] ADDR_TXDATA = 8'h01;
  localparam logic [7:0] ADDR_CTRL   = 8'h02;
  localparam logic [7:0] ADDR_RXDATA = 8'h03;

  localparam int STAT_BUSY    = 0;
  localparam int STAT_DONE    = 1;

  localparam int CTRL_START   = 0;
  localparam int CTRL_NB_LSB  = 1;
  localparam int CTRL_DIV_LSB = 8;
  localparam int CTRL_WP_N    = 16;
  localparam int CTRL_HOLD_N  = 17;
  localparam int CTRL_RESET   = 18;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SHIFT  = 2'd1,
    ST_FINISH = 2'd2
  } state_e;

  typedef struct packed {
    logic       reset;
    logic       hold_n;
    logic       wp_n;
    logic [7:0] div;
    logic [1:0] nb;
  } ctrl_t;

  // CTRL as seen on the bus; START always reads back 0.
  function automatic logic [31:0] ctrl_word(input ctrl_t c);
    logic [31:0] w;
    w                      = '0;
    w[CTRL_NB_LSB +: 2]    = c.nb;
    w[CTRL_DIV_LSB +: 8]   = c.div;
    w[CTRL_WP_N]           = c.wp_n;
    w[CTRL_HOLD_N]         = c.hold_n;
    w[CTRL_RESET]          = c.reset;
    return w;
  endfunction

endpackage

// File: rtl/spi_shift_engine.sv
// Mode-0 SPI shifter with programmable SCK divider: shifts 8..32 bits MSB-first,
// samples MISO on rising SCK, holds CS_N low one half-period after the last fall.
module spi_shift_engine
  import wb_spi_pkg::*;
(
  input  logic        clk_i,
  input  logic        rst_ni,
  input  logic        start_i,
  input  logic [1:0]  nb_i,
  input  logic [7:0]  div_i,
  input  logic [31:0] tx_i,
  input  logic        miso_i,
  output logic        sck_o,
  output logic        mosi_o,
  output logic        cs_n_o,
  output logic        busy_o,
  output logic        done_o,
  output logic [31:0] rx_o
);

  state_e      state_q, state_d;
  logic [7:0]  cnt_q, cnt_d;
  logic [5:0]  bits_q, bits_d;
  logic [31:0] sh_q, sh_d;
  logic [31:0] rx_q, rx_d;
  logic        sck_q, sck_d;
  logic        tick;

  assign tick   = (cnt_q >= div_i);
  assign cs_n_o = (state_q == ST_IDLE);
  assign busy_o = ~cs_n_o;
  assign sck_o  = sck_q;
  assign mosi_o = ~cs_n_o & sh_q[31];
  assign rx_o   = rx_q;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      bits_q  <= '0;
      sh_q    <= '0;
      rx_q    <= '0;
      sck_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      bits_q  <= bits_d;
      sh_q    <= sh_d;
      rx_q    <= rx_d;
      sck_q   <= sck_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    bits_d  = bits_q;
    sh_d    = sh_q;
    rx_d    = rx_q;
    sck_d   = sck_q;
    done_o  = 1'b0;
    case (state_q)
      ST_IDLE: begin
        sck_d = 1'b0;
        if (start_i) begin
          state_d = ST_SHIFT;
          sh_d    = tx_i;
          rx_d    = '0;
          cnt_d   = '0;
          bits_d  = ({4'd0, nb_i} + 6'd1) << 3;
        end
      end
      ST_SHIFT: begin
        if (tick) begin
          cnt_d = '0;
          sck_d = ~sck_q;
          if (!sck_q) begin
            rx_d = {rx_q[30:0], miso_i};
          end else begin
            // Falling edge: advance MOSI unless this was the final bit.
            bits_d = bits_q - 6'd1;
            if (bits_q == 6'd1) state_d = ST_FINISH;
            else                sh_d    = {sh_q[30:0], 1'b0};
          end
        end else begin
          cnt_d = cnt_q + 8'd1;
        end
      end
      ST_FINISH: begin
        if (tick) begin
          state_d = ST_IDLE;
          cnt_d   = '0;
          done_o  = 1'b1;
        end else begin
          cnt_d = cnt_q + 8'd1;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

endmodule

// File: rtl/wb_spi_top.sv
// Wishbone slave front-end of the SPI master: register decode, single-cycle ACK,
// control/status registers and the pin-level strap outputs.
module wb_spi_top
  import wb_spi_pkg::*;
#(
  parameter int unsigned DEFAULT_DIV = 1
) (
  input  logic        CLK_I,
  input  logic        RST_I,
  input  logic [7:0]  ADR_I,
  input  logic [31:0] DAT_I,
  output logic [31:0] DAT_O,
  input  logic        WE_I,
  input  logic        STB_I,
  input  logic        CYC_I,
  output logic        ACK_O,
  output logic        SPI_CLK,
  output logic        SPI_MOSI,
  input  logic        SPI_MISO,
  output logic        SPI_CS_N,
  output logic        SPI_WP_N,
  output logic        SPI_HOLD_N,
  output logic        SPI_RESET
);

  logic        ack_q, ack_d;
  logic        seen_q;
  logic [31:0] dat_q;
  logic [31:0] tx_q;
  ctrl_t       ctrl_q;
  logic        done_q;
  logic        req, wr, start, busy, eng_done;
  logic [31:0] rx, rdata;

  // One ACK per strobe: a held STB must drop before the next access.
  assign req   = STB_I & CYC_I;
  assign ack_d = req & ~seen_q;
  assign wr    = ack_d & WE_I;
  assign start = wr & (ADR_I == ADDR_CTRL) & DAT_I[CTRL_START] & ~busy;

  assign ACK_O      = ack_q;
  assign DAT_O      = dat_q;
  assign SPI_WP_N   = ctrl_q.wp_n;
  assign SPI_HOLD_N = ctrl_q.hold_n;
  assign SPI_RESET  = ctrl_q.reset;

  always_comb begin
    rdata = '0;
    case (ADR_I)
      ADDR_STATUS: begin
        rdata[STAT_BUSY] = busy;
        rdata[STAT_DONE] = done_q;
      end
      ADDR_TXDATA: rdata = tx_q;
      ADDR_CTRL:   rdata = ctrl_word(ctrl_q);
      ADDR_RXDATA: rdata = rx;
      default:     rdata = '0;
    endcase
  end

  always_ff @(posedge CLK_I or negedge RST_I) begin
    if (!RST_I) begin
      ack_q         <= 1'b0;
      seen_q        <= 1'b0;
      dat_q         <= '0;
      tx_q          <= '0;
      done_q        <= 1'b0;
      ctrl_q.reset  <= 1'b0;
      ctrl_q.hold_n <= 1'b1;
      ctrl_q.wp_n   <= 1'b1;
      ctrl_q.div    <= 8'(DEFAULT_DIV);
      ctrl_q.nb     <= 2'd0;
    end else begin
      ack_q  <= ack_d;
      seen_q <= req;
      if (ack_d && !WE_I) dat_q <= rdata;
      if (wr && !busy) begin
        if (ADR_I == ADDR_TXDATA) tx_q <= DAT_I;
        if (ADR_I == ADDR_CTRL) begin
          ctrl_q.nb     <= DAT_I[CTRL_NB_LSB +: 2];
          ctrl_q.div    <= DAT_I[CTRL_DIV_LSB +: 8];
          ctrl_q.wp_n   <= DAT_I[CTRL_WP_N];
          ctrl_q.hold_n <= DAT_I[CTRL_HOLD_N];
          ctrl_q.reset  <= DAT_I[CTRL_RESET];
        end
      end
      if (start)         done_q <= 1'b0;
      else if (eng_done) done_q <= 1'b1;
    end
  end

  // NBYTES comes straight off the bus so a single CTRL write can both
  // program the length and start; DIV is only used after CTRL has settled.
  spi_shift_engine u_eng (
    .clk_i  (CLK_I),
    .rst_ni (RST_I),
    .start_i(start),
    .nb_i   (DAT_I[CTRL_NB_LSB +: 2]),
    .div_i  (ctrl_q.div),
    .tx_i   (tx_q),
    .miso_i (SPI_MISO),
    .sck_o  (SPI_CLK),
    .mosi_o (SPI_MOSI),
    .cs_n_o (SPI_CS_N),
    .busy_o (busy),
    .done_o (eng_done),
    .rx_o   (rx)
  );

endmodule

// File: tb/tb_wb_spi_top.sv
// Self-checking bench for wb_spi_top: register table, directed SPI transfers,
// randomized transfers against a bit-level reference, and async reset abort.
module tb_wb_spi_top;

  localparam int unsigned TB_DEF_DIV = 1;
  localparam int CP = 10;

  logic        CLK_I = 1'b0;
  logic        RST_I;
  logic [7:0]  ADR_I;
  logic [31:0] DAT_I;
  logic [31:0] DAT_O;
  logic        WE_I, STB_I, CYC_I, ACK_O;
  logic        SPI_CLK, SPI_MOSI, SPI_MISO, SPI_CS_N, SPI_WP_N, SPI_HOLD_N, SPI_RESET;

  logic loop_en = 1'b0;
  logic miso_r  = 1'b0;
  assign SPI_MISO = loop_en ? SPI_MOSI : miso_r;

  wb_spi_top #(.DEFAULT_DIV(TB_DEF_DIV)) dut (
    .CLK_I(CLK_I), .RST_I(RST_I), .ADR_I(ADR_I), .DAT_I(DAT_I), .DAT_O(DAT_O),
    .WE_I(WE_I), .STB_I(STB_I), .CYC_I(CYC_I), .ACK_O(ACK_O),
    .SPI_CLK(SPI_CLK), .SPI_MOSI(SPI_MOSI), .SPI_MISO(SPI_MISO), .SPI_CS_N(SPI_CS_N),
    .SPI_WP_N(SPI_WP_N), .SPI_HOLD_N(SPI_HOLD_N), .SPI_RESET(SPI_RESET)
  );

  always #(CP/2) CLK_I = ~CLK_I;

  int n_cmp = 0;
  int n_err = 0;

  // Bus-side observation of the SPI pins.
  logic mosi_q[$];
  logic miso_q[$];
  time  rise_t[$];
  time  t_fall, t_csr;
  int   cs_falls = 0;
  int   viol = 0;

  always @(posedge SPI_CLK) begin
    mosi_q.push_back(SPI_MOSI);
    miso_q.push_back(SPI_MISO);
    rise_t.push_back($time);
  end
  always @(negedge SPI_CLK) t_fall = $time;
  always @(posedge SPI_CS_N) t_csr = $time;
  always @(negedge SPI_CS_N) cs_falls++;
  always @(negedge SPI_CLK or negedge SPI_CS_N) miso_r <= 1'($urandom);
  always @(negedge CLK_I)
    if (SPI_CS_N === 1'b1 && (SPI_CLK !== 1'b0 || SPI_MOSI !== 1'b0)) viol++;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic wb(input logic [7:0] a, input logic [31:0] d, input logic we,
                    output logic [31:0] rd, output int acks);
    rd = '0;
    acks = 0;
    @(negedge CLK_I);
    ADR_I = a; DAT_I = d; WE_I = we; STB_I = 1'b1; CYC_I = 1'b1;
    // STB is held for several cycles on purpose: exactly one ACK may appear.
    for (int i = 0; i < 4; i++) begin
      @(negedge CLK_I);
      if (ACK_O) begin
        acks++;
        rd = DAT_O;
      end
    end
    STB_I = 1'b0; CYC_I = 1'b0; WE_I = 1'b0;
  endtask

  task automatic wr_reg(input string nm, input logic [7:0] a, input logic [31:0] d);
    logic [31:0] rd;
    int acks;
    wb(a, d, 1'b1, rd, acks);
    chk({nm, " ack"}, 32'(acks), 32'd1);
  endtask

  task automatic rd_reg(input string nm, input logic [7:0] a, input logic [31:0] exp);
    logic [31:0] rd;
    int acks;
    wb(a, 32'h0, 1'b0, rd, acks);
    chk({nm, " ack"}, 32'(acks), 32'd1);
    chk({nm, " data"}, rd, exp);
  endtask

  task automatic clear_mon();
    mosi_q.delete();
    miso_q.delete();
    rise_t.delete();
  endtask

  task automatic wait_idle(input string nm);
    int k;
    for (k = 0; k < 5000 && !SPI_CS_N; k++) @(negedge CLK_I);
    chk({nm, " idle timeout"}, 32'(k < 5000), 32'd1);
    repeat (2) @(negedge CLK_I);
  endtask

  // Reference: nbits = 8*(NBYTES); MOSI carries the top nbits of TX in order,
  // SCK period is 2*(DIV+1) cycles, RX is the MISO stream shifted in from the right.
  task automatic check_xfer(input string nm, input logic [31:0] tx, input int nb, input int dv);
    int nbits, bad;
    logic [31:0] mo, rxe;
    nbits = 8 * (nb + 1);
    chk({nm, " pulses"}, 32'(mosi_q.size()), 32'(nbits));
    mo = '0;
    foreach (mosi_q[i]) mo = {mo[30:0], mosi_q[i]};
    chk({nm, " mosi"}, mo, tx >> (32 - nbits));
    bad = 0;
    for (int i = 1; i < rise_t.size(); i++)
      if (rise_t[i] - rise_t[i-1] != time'(2 * (dv + 1) * CP)) bad++;
    chk({nm, " sck period errs"}, 32'(bad), 32'd0);
    chk({nm, " cs hold"}, 32'(t_csr - t_fall), 32'((dv + 1) * CP));
    rxe = '0;
    foreach (miso_q[i]) rxe = {rxe[30:0], miso_q[i]};
    rd_reg({nm, " rxdata"}, 8'h03, rxe);
    rd_reg({nm, " status"}, 8'h00, 32'h2);
  endtask

  typedef struct {
    logic [7:0]  adr;
    logic [31:0] wd;
    logic        we;
    logic [31:0] exp;
  } vec_t;

  vec_t vt[15];

  initial begin
    int cs0, nb, dv;
    logic [31:0] tx, ctl;

    vt[0]  = '{8'h01, 32'hA5C3_0F1E, 1'b1, 32'h0};
    vt[1]  = '{8'h01, 32'h0,         1'b0, 32'hA5C3_0F1E};
    vt[2]  = '{8'h00, 32'h0,         1'b0, 32'h0};
    vt[3]  = '{8'h03, 32'h0,         1'b0, 32'h0};
    vt[4]  = '{8'h02, 32'hFFFF_FFFE, 1'b1, 32'h0};
    vt[5]  = '{8'h02, 32'h0,         1'b0, 32'h0007_FF06};
    vt[6]  = '{8'h10, 32'hDEAD_BEEF, 1'b1, 32'h0};
    vt[7]  = '{8'h10, 32'h0,         1'b0, 32'h0};
    vt[8]  = '{8'hFF, 32'h0,         1'b0, 32'h0};
    vt[9]  = '{8'h00, 32'hFFFF_FFFF, 1'b1, 32'h0};
    vt[10] = '{8'h00, 32'h0,         1'b0, 32'h0};
    vt[11] = '{8'h02, 32'h0001_0200, 1'b1, 32'h0};
    vt[12] = '{8'h02, 32'h0,         1'b0, 32'h0001_0200};
    vt[13] = '{8'h02, 32'h0004_0000, 1'b1, 32'h0};
    vt[14] = '{8'h02, 32'h0,         1'b0, 32'h0004_0000};

    RST_I = 1'b0;
    ADR_I = '0; DAT_I = '0; WE_I = 1'b0; STB_I = 1'b0; CYC_I = 1'b0;
    repeat (3) @(negedge CLK_I);
    chk("rst cs_n",   32'(SPI_CS_N),   32'd1);
    chk("rst wp_n",   32'(SPI_WP_N),   32'd1);
    chk("rst hold_n", 32'(SPI_HOLD_N), 32'd1);
    chk("rst reset",  32'(SPI_RESET),  32'd0);
    chk("rst sck",    32'(SPI_CLK),    32'd0);
    chk("rst ack",    32'(ACK_O),      32'd0);
    chk("rst dat_o",  DAT_O,           32'h0);
    RST_I = 1'b1;
    rd_reg("rst ctrl", 8'h02, 32'h0003_0000 | (32'(TB_DEF_DIV) << 8));
    rd_reg("rst status", 8'h00, 32'h0);

    foreach (vt[i]) begin
      if (vt[i].we) wr_reg($sformatf("vec%0d wr", i), vt[i].adr, vt[i].wd);
      else          rd_reg($sformatf("vec%0d rd", i), vt[i].adr, vt[i].exp);
    end
    chk("pin wp_n",   32'(SPI_WP_N),   32'd0);
    chk("pin hold_n", 32'(SPI_HOLD_N), 32'd0);
    chk("pin reset",  32'(SPI_RESET),  32'd1);

    // 1-byte transfer, DIV=0
    clear_mon();
    wr_reg("b1 tx", 8'h01, 32'h0500_0000);
    wr_reg("b1 ctrl", 8'h02, 32'h0003_0001);
    wait_idle("b1");
    check_xfer("b1", 32'h0500_0000, 0, 0);
    chk("pin wp_n restored", 32'(SPI_WP_N), 32'd1);

    // 4-byte loopback, DIV=3
    clear_mon();
    loop_en = 1'b1;
    wr_reg("lb tx", 8'h01, 32'h0312_3456);
    wr_reg("lb ctrl", 8'h02, 32'h0003_0307);
    wait_idle("lb");
    check_xfer("lb", 32'h0312_3456, 3, 3);
    rd_reg("lb rx const", 8'h03, 32'h0312_3456);
    loop_en = 1'b0;

    // Writes while busy are acked but dropped; no second transfer follows.
    clear_mon();
    cs0 = cs_falls;
    wr_reg("busy tx", 8'h01, 32'h1122_3344);
    wr_reg("busy ctrl", 8'h02, 32'h0003_0107);
    wr_reg("busy tx2", 8'h01, 32'hFFFF_FFFF);
    wr_reg("busy ctrl2", 8'h02, 32'h0003_0001);
    wait_idle("busy");
    repeat (20) @(negedge CLK_I);
    check_xfer("busy", 32'h1122_3344, 3, 1);
    chk("busy cs falls", 32'(cs_falls - cs0), 32'd1);
    rd_reg("busy txdata", 8'h01, 32'h1122_3344);
    rd_reg("busy ctrl rd", 8'h02, 32'h0003_0106);

    for (int it = 0; it < 6; it++) begin
      tx = $urandom;
      nb = int'($urandom_range(0, 3));
      dv = int'($urandom_range(0, 3));
      ctl = 32'h0003_0001 | (32'(dv) << 8) | (32'(nb) << 1);
      clear_mon();
      wr_reg($sformatf("rnd%0d tx", it), 8'h01, tx);
      wr_reg($sformatf("rnd%0d ctrl", it), 8'h02, ctl);
      wait_idle($sformatf("rnd%0d", it));
      check_xfer($sformatf("rnd%0d", it), tx, nb, dv);
    end

    // Async reset in the middle of a shift aborts immediately.
    wr_reg("ar tx", 8'h01, 32'hCAFE_F00D);
    wr_reg("ar ctrl", 8'h02, 32'h0003_0307);
    repeat (10) @(negedge CLK_I);
    chk("ar busy cs_n", 32'(SPI_CS_N), 32'd0);
    #2 RST_I = 1'b0;
    #1;
    chk("ar cs_n", 32'(SPI_CS_N), 32'd1);
    chk("ar sck",  32'(SPI_CLK),  32'd0);
    chk("ar mosi", 32'(SPI_MOSI), 32'd0);
    @(negedge CLK_I);
    RST_I = 1'b1;
    rd_reg("ar status", 8'h00, 32'h0);
    rd_reg("ar txdata", 8'h01, 32'h0);
    rd_reg("ar rxdata", 8'h03, 32'h0);
    rd_reg("ar ctrl", 8'h02, 32'h0003_0000 | (32'(TB_DEF_DIV) << 8));

    chk("idle pin violations", 32'(viol), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #(CP * 60000);
    $display("FAIL global timeout: got running expected finished");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/wb_spi_top.md
WB_SPI_TOP -- requirements
Module: wb_spi_top

Interface
REQ-001 SHALL have parameter DEFAULT_DIV, default 1, reset value of CTRL.DIV (SPI clock divider).
REQ-002 SHALL have port CLK_I  input  1  system clock; all logic on rising edge.
REQ-003 SHALL have port RST_I  input  1  reset, asynchronous and active-low.
REQ-004 SHALL have Wishbone slave ports ADR_I in 8, DAT_I in 32, DAT_O out 32, WE_I in 1, STB_I in 1, CYC_I in 1, ACK_O out 1.
REQ-005 SHALL have SPI ports SPI_CLK out 1, SPI_MOSI out 1, SPI_MISO in 1, SPI_CS_N out 1, SPI_WP_N out 1, SPI_HOLD_N out 1, SPI_RESET out 1.

Function
REQ-006 SHALL decode the register map as: 0x00 STATUS (RO), 0x01 TXDATA (RW), 0x02 CTRL (RW), 0x03 RXDATA (RO); other addresses read 0, writes ignored.
REQ-007 SHALL define STATUS as: [0] BUSY, [1] DONE (set at transfer end, cleared by START); other bits 0.
REQ-008 SHALL define CTRL as: [0] START (write-1 pulse, reads 0), [2:1] NBYTES-1, [15:8] DIV, [16] WP_N, [17] HOLD_N, [18] RESET; other bits read 0.
REQ-009 SHALL drive SPI_WP_N, SPI_HOLD_N, SPI_RESET combinationally from CTRL[16], CTRL[17], CTRL[18].
REQ-010 SHALL assert ACK_O for exactly one cycle, one cycle after the first edge where STB_I&CYC_I are high; no new ACK until STB_I deasserts.
REQ-011 SHALL register DAT_O with the addressed register in the same cycle ACK_O is set, holding it until the next read.
REQ-012 SHALL perform writes in the ACK cycle; writes to TXDATA/CTRL while BUSY are ACKed but discarded.
REQ-013 SHALL, on START with BUSY=0, assert BUSY, clear DONE, drive SPI_CS_N low, and shift (NBYTES)*8 bits of TXDATA MSB-first beginning at TXDATA[31].
REQ-014 SHALL use SPI mode 0: SPI_CLK idle low, MOSI changed on SCK falling edge (first bit valid when CS_N falls), MISO sampled on SCK rising edge.
REQ-015 SHALL toggle SPI_CLK every DIV+1 CLK_I cycles (SCK period 2*(DIV+1) cycles); DIV=0 gives CLK_I/2.
REQ-016 SHALL shift sampled MISO bits into RXDATA LSB-first-in (after n bytes, last received byte in RXDATA[7:0]); RXDATA cleared at START.
REQ-017 SHALL, after the last falling SCK edge, hold CS_N low one half-period, then raise CS_N, clear BUSY, set DONE.
REQ-018 SHALL implement states IDLE -> SHIFT -> FINISH -> IDLE; START while not IDLE ignored.
REQ-019 SHALL hold SPI_MOSI low and SPI_CLK low whenever CS_N is high.

Reset
REQ-020 SHALL, while RST_I low, force: ACK_O 0, DAT_O 0, SPI_CLK 0, SPI_MOSI 0, SPI_CS_N 1, TXDATA 0, RXDATA 0, STATUS 0, CTRL = {WP_N=1, HOLD_N=1, RESET=0, DIV=DEFAULT_DIV, NBYTES-1=0}, state IDLE.
REQ-021 SHALL abort any transfer on reset mid-operation, raising CS_N immediately.

Structure
REQ-022 SHALL place register addresses, CTRL/STATUS bit positions and state encodings in shared package wb_spi_pkg.
REQ-023 SHALL split the shifter/clock generator into one sub-module spi_shift_engine; Wishbone decode and registers stay in wb_spi_top.

Verification
REQ-024 SHALL check reset: RST_I low -> CS_N=1, WP_N=1, HOLD_N=1, SPI_CLK=0, reads of 0x02 return 0x00030000|DEFAULT_DIV<<8.
REQ-025 SHALL check register access: write 0x01=0xA5C3_0F1E, read 0x01 -> 0xA5C30F1E with ACK_O one cycle wide.
REQ-026 SHALL check 1-byte transfer: TXDATA=0x0500_0000, CTRL=0x0003_0001 (DIV=0) -> MOSI bits 00000101, 8 SCK pulses period 2 cycles, CS_N low then high, STATUS=0x2.
REQ-027 SHALL check 4-byte loopback (MISO tied to MOSI): TXDATA=0x0312_3456, NBYTES-1=3, DIV=3 -> 32 SCK pulses period 8 cycles, RXDATA=0x03123456.
REQ-028 SHALL check busy protection: write TXDATA=0xFFFFFFFF and START during transfer -> ACKed, TXDATA unchanged, single transfer only.
REQ-029 SHALL check async reset mid-transfer: RST_I low during SHIFT -> CS_N=1 same cycle, STATUS=0 after release.
